// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined CPU: fetch FSM states, default
// datapath widths, reset PC and the bubble encoding.
package cpu_pkg;

    localparam int CPU_AW = 16;
    localparam int CPU_DW = 16;

    localparam logic [15:0] CPU_RESET_PC = 16'h0000;
    localparam logic [15:0] CPU_NOP_INST = 16'h0000;

    typedef enum logic [1:0] {
        ISSUE   = 2'd0,
        WAIT    = 2'd1,
        HOLD    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry skid register that parks an instruction which returned from memory
// while the downstream stage was stalled.
module if_hold_buf
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [DW-1:0] load_data,
    output logic          full,
    output logic [DW-1:0] data
);

    logic          full_r;
    logic [DW-1:0] data_r;

    // Buffer state; clear wins over load so a flush can never leave stale data.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= {DW{1'b0}};
        end else if (clear) begin
            full_r <= 1'b0;
            data_r <= {DW{1'b0}};
        end else if (load) begin
            full_r <= 1'b1;
            data_r <= load_data;
        end else begin
            full_r <= full_r;
            data_r <= data_r;
        end
    end

    assign full = full_r;
    assign data = data_r;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding requests to
// instruction memory and feeds the IF/ID register, honouring stall and redirect.
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int            AW       = CPU_AW,
    parameter int            DW       = CPU_DW,
    parameter logic [AW-1:0] RESET_PC = AW'(CPU_RESET_PC)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] inst_out,
    output logic [AW-1:0] pc_plus1_out,
    output logic          exec_out
);

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DW-1:0] NOP    = DW'(CPU_NOP_INST);

    fetch_state_e  state_r;
    fetch_state_e  state_n_s;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_n_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] pcp1_r;
    logic [AW-1:0] pcp1_n_s;
    logic [DW-1:0] inst_r;
    logic [DW-1:0] inst_n_s;
    logic [DW-1:0] inst_d_s;
    logic          exec_r;
    logic          exec_n_s;
    logic          exec_d_s;
    logic          req_s;
    logic          hold_load_s;
    logic          hold_clear_s;
    logic          hold_full_s;
    logic [DW-1:0] hold_data_s;

    // Wraps naturally modulo 2^AW.
    assign pc_inc_s = pc_r + PC_ONE;

    if_hold_buf #(
        .DW (DW)
    ) u_hold (
        .clk       (clk),
        .rst       (rst),
        .load      (hold_load_s),
        .clear     (hold_clear_s),
        .load_data (imem_rdata),
        .full      (hold_full_s),
        .data      (hold_data_s)
    );

    // Next-state, PC and IF/ID output decisions for each fetch state.
    always_comb begin
        state_n_s    = state_r;
        pc_n_s       = pc_r;
        inst_n_s     = inst_r;
        pcp1_n_s     = pcp1_r;
        exec_n_s     = exec_r;
        req_s        = 1'b0;
        hold_load_s  = 1'b0;
        hold_clear_s = 1'b0;

        case (state_r)
            ISSUE: begin
                if (redirect) begin
                    pc_n_s = redirect_pc;
                end else begin
                    req_s     = 1'b1;
                    state_n_s = WAIT;
                end
                if (!stall) begin
                    exec_n_s = 1'b0;
                end else begin
                    exec_n_s = exec_r;
                end
            end
            WAIT: begin
                if (redirect) begin
                    pc_n_s    = redirect_pc;
                    state_n_s = imem_valid ? ISSUE : DISCARD;
                end else if (imem_valid) begin
                    if (!stall) begin
                        inst_n_s  = imem_rdata;
                        pcp1_n_s  = pc_inc_s;
                        exec_n_s  = 1'b1;
                        pc_n_s    = pc_inc_s;
                        state_n_s = ISSUE;
                    end else begin
                        hold_load_s = 1'b1;
                        state_n_s   = HOLD;
                    end
                end else if (!stall) begin
                    exec_n_s = 1'b0;
                end else begin
                    exec_n_s = exec_r;
                end
            end
            HOLD: begin
                if (redirect) begin
                    hold_clear_s = 1'b1;
                    pc_n_s       = redirect_pc;
                    state_n_s    = ISSUE;
                end else if (!stall && hold_full_s) begin
                    inst_n_s     = hold_data_s;
                    pcp1_n_s     = pc_inc_s;
                    exec_n_s     = 1'b1;
                    pc_n_s       = pc_inc_s;
                    hold_clear_s = 1'b1;
                    state_n_s    = ISSUE;
                end else begin
                    state_n_s = HOLD;
                end
            end
            DISCARD: begin
                if (redirect) begin
                    pc_n_s = redirect_pc;
                end else begin
                    pc_n_s = pc_r;
                end
                if (imem_valid) begin
                    state_n_s = ISSUE;
                end else begin
                    state_n_s = DISCARD;
                end
                if (!stall) begin
                    exec_n_s = 1'b0;
                end else begin
                    exec_n_s = exec_r;
                end
            end
            default: begin
                state_n_s = ISSUE;
            end
        endcase
    end

    // A redirect flushes the IF/ID payload whatever the state or stall.
    assign inst_d_s = redirect ? NOP  : inst_n_s;
    assign exec_d_s = redirect ? 1'b0 : exec_n_s;

    // State, PC and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ISSUE;
            pc_r    <= RESET_PC;
            inst_r  <= {DW{1'b0}};
            pcp1_r  <= {AW{1'b0}};
            exec_r  <= 1'b0;
        end else begin
            state_r <= state_n_s;
            pc_r    <= pc_n_s;
            inst_r  <= inst_d_s;
            pcp1_r  <= pcp1_n_s;
            exec_r  <= exec_d_s;
        end
    end

    // Request is decoded from the registered state so a 1-cycle memory keeps the
    // two-cycle fetch loop; it is suppressed while reset is held.
    assign imem_req     = req_s & ~rst;
    assign imem_addr    = imem_req ? pc_r : {AW{1'b0}};
    assign inst_out     = inst_r;
    assign pc_plus1_out = pcp1_r;
    assign exec_out     = exec_r;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed, table-driven bench for if_fetch_unit with a behavioural
// variable-latency instruction memory; a second instance covers RESET_PC wrap.
module tb_if_fetch_unit;
    import cpu_pkg::*;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] inst_out;
    logic [15:0] pc_plus1_out;
    logic        exec_out;

    logic        rst2;
    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [15:0] redirect_pc2 = 16'h0000;
    logic        imem_req2;
    logic [15:0] imem_addr2;
    logic        imem_valid2 = 1'b0;
    logic [15:0] imem_rdata2 = 16'h0000;
    logic [15:0] inst_out2;
    logic [15:0] pc_plus1_out2;
    logic        exec_out2;

    int n_pass  = 0;
    int n_total = 0;
    int lat     = 1;

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .pc_plus1_out(pc_plus1_out), .exec_out(exec_out)
    );

    if_fetch_unit #(.RESET_PC(16'hFFFF)) dut2 (
        .clk(clk), .rst(rst2), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_valid(imem_valid2), .imem_rdata(imem_rdata2), .inst_out(inst_out2),
        .pc_plus1_out(pc_plus1_out2), .exec_out(exec_out2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mem_fn(input logic [15:0] a);
        return (a == 16'h0005) ? 16'h1234 : (a ^ 16'hA5A5);
    endfunction

    // Main memory: captures a request mid-cycle, answers lat cycles later for one cycle.
    logic        mem_pend = 1'b0;
    int          mem_cnt  = 0;
    logic [15:0] mem_a    = 16'h0000;
    always begin
        @(posedge clk);
        #1;
        imem_valid = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
        end else if (mem_pend) begin
            if (mem_cnt <= 1) begin
                imem_valid = 1'b1;
                imem_rdata = mem_fn(mem_a);
                mem_pend   = 1'b0;
            end else begin
                mem_cnt = mem_cnt - 1;
            end
        end
        @(negedge clk);
        if (imem_req && !rst) begin
            mem_pend = 1'b1;
            mem_cnt  = lat;
            mem_a    = imem_addr;
        end
    end

    // Second memory, fixed 1-cycle latency.
    logic        mem2_pend = 1'b0;
    logic [15:0] mem2_a    = 16'h0000;
    always begin
        @(posedge clk);
        #1;
        imem_valid2 = 1'b0;
        if (rst2) begin
            mem2_pend = 1'b0;
        end else if (mem2_pend) begin
            imem_valid2 = 1'b1;
            imem_rdata2 = mem_fn(mem2_a);
            mem2_pend   = 1'b0;
        end
        @(negedge clk);
        if (imem_req2 && !rst2) begin
            mem2_pend = 1'b1;
            mem2_a    = imem_addr2;
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total = n_total + 1;
        if (act === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        r;
        logic        s;
        logic        rd;
        logic [15:0] rpc;
        int          l;
        logic        req;
        logic [15:0] addr;
        logic [15:0] inst;
        logic [15:0] p1;
        logic        ex;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic s, input logic rd, input logic [15:0] rpc,
                       input int l, input logic req, input logic [15:0] addr,
                       input logic [15:0] inst, input logic [15:0] p1, input logic ex);
        vec_t v;
        v.r = r; v.s = s; v.rd = rd; v.rpc = rpc; v.l = l;
        v.req = req; v.addr = addr; v.inst = inst; v.p1 = p1; v.ex = ex;
        vq.push_back(v);
    endtask

    initial begin
        logic [1:0] st;
        rst = 1'b1; rst2 = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;

        // rst, stall, redirect, redirect_pc, latency | req, addr, inst, pc+1, exec
        add(1, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0); // reset state
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 16'h0000, 0); // issue 0
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0000, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0001, 16'hA5A5, 16'h0001, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A5, 16'h0001, 0); // bubble
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0002, 16'hA5A4, 16'h0002, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A4, 16'h0002, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0003, 16'hA5A7, 16'h0003, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A7, 16'h0003, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0004, 16'hA5A6, 16'h0004, 1);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A6, 16'h0004, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0005, 16'hA5A1, 16'h0005, 1); // issue 5
        add(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A1, 16'h0005, 0); // stall, 1234 returns
        add(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A1, 16'h0005, 0); // HOLD, frozen
        add(0, 1, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A1, 16'h0005, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'hA5A1, 16'h0005, 0); // drop stall
        add(0, 0, 0, 16'h0000, 3, 1, 16'h0006, 16'h1234, 16'h0006, 1); // held delivery, slow fetch
        add(0, 0, 1, 16'h0040, 3, 0, 16'h0000, 16'h1234, 16'h0006, 0); // redirect in WAIT
        add(0, 0, 0, 16'h0000, 3, 0, 16'h0000, 16'h0000, 16'h0006, 0); // DISCARD
        add(0, 0, 0, 16'h0000, 3, 0, 16'h0000, 16'h0000, 16'h0006, 0); // late data dropped
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0040, 16'h0000, 16'h0006, 0);
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0006, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0041, 16'hA5E5, 16'h0041, 1);
        add(0, 1, 1, 16'h0080, 1, 0, 16'h0000, 16'hA5E5, 16'h0041, 0); // redirect+valid+stall
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0080, 16'h0000, 16'h0041, 0); // flushed
        add(0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 16'h0041, 0);
        add(0, 0, 0, 16'h0000, 1, 1, 16'h0081, 16'hA525, 16'h0081, 1);

        // RESET_PC = FFFF instance: PC and pc+1 wrap to zero.
        repeat (2) @(posedge clk);
        #2 rst2 = 1'b0;
        @(negedge clk);
        chk("wrap_req0", {15'd0, imem_req2}, 16'h0001);
        chk("wrap_addr0", imem_addr2, 16'hFFFF);
        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("wrap_inst", inst_out2, 16'h5A5A);
        chk("wrap_pcp1", pc_plus1_out2, 16'h0000);
        chk("wrap_exec", {15'd0, exec_out2}, 16'h0001);
        chk("wrap_req1", {15'd0, imem_req2}, 16'h0001);
        chk("wrap_addr1", imem_addr2, 16'h0000);
        @(posedge clk);
        #2 rst2 = 1'b1;

        foreach (vq[i]) begin
            @(posedge clk);
            #2;
            rst = vq[i].r; stall = vq[i].s; redirect = vq[i].rd;
            redirect_pc = vq[i].rpc; lat = vq[i].l;
            @(negedge clk);
            chk($sformatf("v%0d_req", i), {15'd0, imem_req}, {15'd0, vq[i].req});
            chk($sformatf("v%0d_addr", i), imem_addr, vq[i].addr);
            chk($sformatf("v%0d_inst", i), inst_out, vq[i].inst);
            chk($sformatf("v%0d_pcp1", i), pc_plus1_out, vq[i].p1);
            chk($sformatf("v%0d_exec", i), {15'd0, exec_out}, {15'd0, vq[i].ex});
        end

        // Reset while parked in HOLD.
        @(posedge clk);
        #2 stall = 1'b1; redirect = 1'b0; lat = 1;
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        st = dut.state_r;
        chk("hold_state", {14'd0, st}, {14'd0, HOLD});
        chk("hold_full", {15'd0, dut.hold_full_s}, 16'h0001);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_inst", inst_out, 16'h0000);
        chk("rst_pcp1", pc_plus1_out, 16'h0000);
        chk("rst_exec", {15'd0, exec_out}, 16'h0000);
        chk("rst_req", {15'd0, imem_req}, 16'h0000);
        chk("rst_addr", imem_addr, 16'h0000);
        chk("rst_full", {15'd0, dut.hold_full_s}, 16'h0000);
        @(posedge clk);
        #2 rst = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("post_rst_req", {15'd0, imem_req}, 16'h0001);
        chk("post_rst_addr", imem_addr, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage of the 16-bit pipelined CPU; producer side of the IF/ID pipeline interface.
- Owns the program counter and issues single-outstanding requests to instruction memory.
- Delivers each instruction with its PC+1 and an exec valid flag to the IF/ID register.
- Honours the hazard-unit stall by buffering a returning instruction; honours branch/jump redirects by squashing the in-flight fetch.

Parameters:
- AW, 16, PC / instruction-memory address width.
- DW, 16, instruction width.
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  1  hazard stall from the hazard unit; downstream does not capture while high.
- redirect  in  1  taken branch/jump from the execute stage.
- redirect_pc  in  AW  branch/jump target.
- imem_req  out  1  single-cycle fetch request strobe.
- imem_addr  out  AW  fetch address; valid when imem_req=1.
- imem_valid  in  1  response strobe, at least 1 cycle after imem_req.
- imem_rdata  in  DW  instruction word; valid when imem_valid=1.
- inst_out  out  DW  instruction to IF/ID.
- pc_plus1_out  out  AW  address of inst_out plus 1, to IF/ID.
- exec_out  out  1  inst_out is a real instruction (0 = bubble).

Behaviour:
- Reset:
  - pc=RESET_PC, state=ISSUE.
  - inst_out=0, pc_plus1_out=0, exec_out=0, imem_req=0, imem_addr=0, hold buffer cleared.
  - Instruction memory shares rst, so no stale response arrives after reset. Reset mid-fetch simply abandons the fetch.
- Outputs inst_out, pc_plus1_out and exec_out are registered. They change only on a delivery, a bubble, or a flush.
- While stall=1, the outputs hold their values, except on a flush.
- Only one request may be outstanding. imem_req is high for exactly one cycle per request.
- States:
  - ISSUE:
    - If redirect: pc<=redirect_pc, no request, stay ISSUE.
    - Else: imem_req=1, imem_addr=pc, go to WAIT.
    - If stall=0, exec_out<=0 (bubble) this cycle.
  - WAIT, priority redirect > imem_valid:
    - redirect with imem_valid=1: drop the data, pc<=redirect_pc, go to ISSUE.
    - redirect with imem_valid=0: pc<=redirect_pc, go to DISCARD.
    - imem_valid with stall=0: deliver (inst_out<=imem_rdata, pc_plus1_out<=pc+1, exec_out<=1), pc<=pc+1, go to ISSUE.
    - imem_valid with stall=1: hold_inst<=imem_rdata, go to HOLD; outputs unchanged.
    - No event with stall=0: exec_out<=0 (bubble).
  - HOLD:
    - redirect: clear buffer, pc<=redirect_pc, go to ISSUE.
    - stall=0: deliver hold_inst with pc+1, exec_out<=1, pc<=pc+1, go to ISSUE.
    - Otherwise remain in HOLD.
  - DISCARD:
    - Wait for imem_valid and drop the data, then go to ISSUE.
    - A further redirect updates pc only.
    - If stall=0, exec_out<=0.
- Flush: any cycle with redirect=1 forces inst_out<=0 and exec_out<=0, regardless of stall. pc_plus1_out holds.
- Latency: minimum fetch-to-delivery is 2 cycles with 1-cycle memory (ISSUE, WAIT). Peak throughput is one instruction per 2 cycles.
- Arithmetic: pc+1 is modulo 2^AW. 16'hFFFF wraps to 16'h0000 in both pc and pc_plus1_out.
- Simultaneous events:
  - redirect beats stall, imem_valid and hold.
  - stall never blocks request issue; only delivery waits.

Decomposition:
- Shared cpu_pkg holds:
  - fetch state enum {ISSUE, WAIT, HOLD, DISCARD};
  - AW/DW defaults;
  - RESET_PC;
  - NOP/bubble encoding 16'h0000.
- One natural sub-module: if_hold_buf, a one-entry skid register with load, clear, full flag and data. The FSM and PC logic stay in the top module.

Test Plan:
- Reset then run with 1-cycle memory returning rdata=addr^16'hA5A5, stall=0:
  - imem_addr sequence 0,1,2.
  - Deliveries {inst=16'hA5A5,pc_plus1=1}, {16'hA5A4,2}, {16'hA5A7,3}, each with exec_out=1.
  - Bubble cycles between deliveries show exec_out=0.
- stall=1 raised in WAIT, response 16'h1234 arrives at pc=5:
  - Outputs frozen; state HOLD; no new imem_req.
  - Drop stall: next cycle inst_out=16'h1234, pc_plus1_out=6, exec_out=1, then imem_addr=6.
- redirect=1, redirect_pc=16'h0040 in WAIT, 3-cycle memory:
  - Late response is dropped; exec_out=0, inst_out=0.
  - Next imem_addr=16'h0040; delivered pc_plus1_out=16'h0041.
- redirect and imem_valid in the same cycle while stall=1:
  - No delivery, buffer unused, flush outputs.
  - Next request at the target.
- RESET_PC=16'hFFFF:
  - First delivery pc_plus1_out=16'h0000.
  - Next imem_addr=16'h0000.
- Assert rst while in HOLD:
  - Next cycle all outputs 0, buffer empty.
  - First request after rst deasserts at RESET_PC.
